// File: rtl/video_sig_gen_if.sv
// rtl/video_sig_gen_if.sv - raster timing bundle shared by the generator and its consumers
interface video_sig_gen_if;
   logic [10:0] hcount_out;
   logic [9:0]  vcount_out;
   logic        hs_out;
   logic        vs_out;
   logic        ad_out;
   logic        nf_out;
   logic [5:0]  fc_out;

   modport master (
      output hcount_out, vcount_out, hs_out, vs_out, ad_out, nf_out, fc_out
   );

   modport slave (
      input hcount_out, vcount_out, hs_out, vs_out, ad_out, nf_out, fc_out
   );
endinterface

// File: rtl/video_sig_gen.sv
// rtl/video_sig_gen.sv - raster timing generator: coordinates, syncs, active draw, frame strobe/count
module video_sig_gen #(
   parameter int ACTIVE_H = 1280,
   parameter int H_FRONT  = 110,
   parameter int H_SYNC   = 40,
   parameter int H_BACK   = 220,
   parameter int ACTIVE_V = 720,
   parameter int V_FRONT  = 5,
   parameter int V_SYNC   = 5,
   parameter int V_BACK   = 20,
   parameter int FPS      = 60
) (
   input  logic              clk_in,
   input  logic              rst_n_in,
   video_sig_gen_if.master   vid
);
   localparam int H_TOTAL  = ACTIVE_H + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL  = ACTIVE_V + V_FRONT + V_SYNC + V_BACK;
   localparam int HS_START = ACTIVE_H + H_FRONT;
   localparam int HS_END   = HS_START + H_SYNC;
   localparam int VS_START = ACTIVE_V + V_FRONT;
   localparam int VS_END   = VS_START + V_SYNC;

   typedef enum logic {IDLE, RUN} state_t;
   state_t state;

   logic [10:0] h_nxt;
   logic [9:0]  v_nxt;
   logic        nf_nxt;

   // Every registered output is derived from the coordinate being loaded,
   // so all of them describe the same pixel in a given cycle.
   always_comb begin
      h_nxt  = '0;
      v_nxt  = '0;
      nf_nxt = 1'b0;
      if (state == RUN) begin
         if (vid.hcount_out == 11'(H_TOTAL - 1)) begin
            h_nxt = '0;
            if (vid.vcount_out == 10'(V_TOTAL - 1))
               v_nxt = '0;
            else
               v_nxt = vid.vcount_out + 10'd1;
         end else begin
            h_nxt = vid.hcount_out + 11'd1;
            v_nxt = vid.vcount_out;
         end
         nf_nxt = (h_nxt == 11'(ACTIVE_H)) && (v_nxt == 10'(ACTIVE_V));
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state          <= IDLE;
         vid.hcount_out <= '0;
         vid.vcount_out <= '0;
         vid.hs_out     <= 1'b0;
         vid.vs_out     <= 1'b0;
         vid.ad_out     <= 1'b0;
         vid.nf_out     <= 1'b0;
         vid.fc_out     <= '0;
      end else begin
         state          <= RUN;
         vid.hcount_out <= h_nxt;
         vid.vcount_out <= v_nxt;
         vid.ad_out     <= (h_nxt < 11'(ACTIVE_H)) && (v_nxt < 10'(ACTIVE_V));
         vid.hs_out     <= (h_nxt >= 11'(HS_START)) && (h_nxt < 11'(HS_END));
         vid.vs_out     <= (v_nxt >= 10'(VS_START)) && (v_nxt < 10'(VS_END));
         vid.nf_out     <= nf_nxt;
         if (nf_nxt)
            vid.fc_out <= (vid.fc_out == 6'(FPS - 1)) ? 6'd0 : vid.fc_out + 6'd1;
      end
   end
endmodule

// File: tb/tb_video_sig_gen.sv
// tb/tb_video_sig_gen.sv - directed bench for video_sig_gen at 720p and small raster sizes
module tb_video_sig_gen;
   logic clk_in = 1'b0;
   logic rst_big;
   logic rst_small;

   always #5 clk_in = ~clk_in;

   video_sig_gen_if big_if ();
   video_sig_gen_if small_if ();

   video_sig_gen dut_big (
      .clk_in   (clk_in),
      .rst_n_in (rst_big),
      .vid      (big_if.master)
   );

   video_sig_gen #(
      .ACTIVE_H (4), .H_FRONT (1), .H_SYNC (1), .H_BACK (1),
      .ACTIVE_V (3), .V_FRONT (1), .V_SYNC (1), .V_BACK (1),
      .FPS      (3)
   ) dut_small (
      .clk_in   (clk_in),
      .rst_n_in (rst_small),
      .vid      (small_if.master)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] big_all();
      return {1'b0, big_if.hcount_out, big_if.vcount_out, big_if.hs_out, big_if.vs_out,
              big_if.ad_out, big_if.nf_out, big_if.fc_out};
   endfunction

   function automatic logic [31:0] small_all();
      return {1'b0, small_if.hcount_out, small_if.vcount_out, small_if.hs_out, small_if.vs_out,
              small_if.ad_out, small_if.nf_out, small_if.fc_out};
   endfunction

   initial begin
      int ad_cnt, ad_last, hs_cnt, hs_first, hs_last, hbad, vbad, other;
      int eh, ev, efc, last_nf, nf_seen;
      int bad_h, bad_v, bad_ad, bad_hs, bad_vs, bad_nf, bad_fc, bad_gap;
      logic ead, ehs, evs, enf;

      rst_big   = 1'b0;
      rst_small = 1'b0;
      #1;
      chk("powerup_big_zero", big_all(), 0);
      chk("powerup_small_zero", small_all(), 0);

      // Reset held for 10 cycles: nothing moves
      for (int i = 0; i < 10; i++) begin
         @(negedge clk_in);
         chk("rst_hold_big_zero", big_all(), 0);
      end

      rst_big = 1'b1;
      @(negedge clk_in);
      chk("first_h", big_if.hcount_out, 0);
      chk("first_v", big_if.vcount_out, 0);
      chk("first_ad", big_if.ad_out, 1);
      chk("first_hs_vs_nf", {big_if.hs_out, big_if.vs_out, big_if.nf_out}, 0);
      chk("first_fc", big_if.fc_out, 0);
      @(negedge clk_in);
      chk("second_h", big_if.hcount_out, 1);

      // One full 720p line
      ad_cnt = 1; ad_last = 0; hs_cnt = 0; hs_first = -1; hs_last = -1;
      hbad = 0; vbad = 0; other = 0;
      for (int k = 1; k < 1650; k++) begin
         if (k > 1) @(negedge clk_in);
         if (big_if.hcount_out != 11'(k)) hbad++;
         if (big_if.vcount_out != 0) vbad++;
         if (big_if.ad_out) begin ad_cnt++; ad_last = k; end
         if (big_if.hs_out) begin
            hs_cnt++;
            if (hs_first < 0) hs_first = k;
            hs_last = k;
         end
         if (big_if.vs_out || big_if.nf_out) other++;
      end
      chk("line_hcount_seq", hbad, 0);
      chk("line_vcount_const", vbad, 0);
      chk("line_ad_count", ad_cnt, 1280);
      chk("line_ad_last", ad_last, 1279);
      chk("line_hs_count", hs_cnt, 40);
      chk("line_hs_first", hs_first, 1390);
      chk("line_hs_last", hs_last, 1429);
      chk("line_no_vs_nf", other, 0);
      @(negedge clk_in);
      chk("line_wrap_h", big_if.hcount_out, 0);
      chk("line_wrap_v", big_if.vcount_out, 1);
      chk("line_wrap_ad", big_if.ad_out, 1);

      // Async reset mid-line between edges
      for (int i = 0; i < 2000 && big_if.hcount_out != 11'd500; i++) @(negedge clk_in);
      chk("mid_reach_500", big_if.hcount_out, 500);
      #2 rst_big = 1'b0;
      #1 chk("mid_rst_async_zero", big_all(), 0);
      @(negedge clk_in);
      chk("mid_rst_held_zero", big_all(), 0);
      rst_big = 1'b1;
      @(negedge clk_in);
      chk("mid_restart_hv", {big_if.hcount_out, big_if.vcount_out}, 0);
      chk("mid_restart_ad", big_if.ad_out, 1);
      chk("mid_restart_fc", big_if.fc_out, 0);

      // Small raster: 7x6 = 42 cycles per frame, 60 frames
      @(negedge clk_in);
      rst_small = 1'b1;
      efc = 0; last_nf = -1; nf_seen = 0;
      bad_h = 0; bad_v = 0; bad_ad = 0; bad_hs = 0; bad_vs = 0; bad_nf = 0; bad_fc = 0; bad_gap = 0;
      for (int n = 0; n < 60 * 42; n++) begin
         @(negedge clk_in);
         eh  = n % 7;
         ev  = (n / 7) % 6;
         ead = (eh < 4) && (ev < 3);
         ehs = (eh == 5);
         evs = (ev == 4);
         enf = (eh == 4) && (ev == 3);
         if (enf) begin
            efc = (efc + 1) % 3;
            if (last_nf >= 0 && n - last_nf != 42) bad_gap++;
            last_nf = n;
         end
         if (small_if.hcount_out != 11'(eh)) bad_h++;
         if (small_if.vcount_out != 10'(ev)) bad_v++;
         if (small_if.ad_out !== ead) bad_ad++;
         if (small_if.hs_out !== ehs) bad_hs++;
         if (small_if.vs_out !== evs) bad_vs++;
         if (small_if.nf_out !== enf) bad_nf++;
         if (small_if.fc_out != 6'(efc)) bad_fc++;
         if (small_if.nf_out) nf_seen++;
      end
      chk("small_hcount", bad_h, 0);
      chk("small_vcount", bad_v, 0);
      chk("small_ad", bad_ad, 0);
      chk("small_hs", bad_hs, 0);
      chk("small_vs", bad_vs, 0);
      chk("small_nf", bad_nf, 0);
      chk("small_fc", bad_fc, 0);
      chk("small_nf_gap", bad_gap, 0);
      chk("small_nf_total", nf_seen, 60);

      // Frame counter restarts at 0 after a mid-frame reset
      repeat (30) @(negedge clk_in);
      chk("small_fc_before_rst", small_if.fc_out, 1);
      #2 rst_small = 1'b0;
      #1 chk("small_rst_zero", small_all(), 0);
      @(negedge clk_in);
      rst_small = 1'b1;
      @(negedge clk_in);
      chk("small_restart_hv", {small_if.hcount_out, small_if.vcount_out}, 0);
      chk("small_restart_fc", small_if.fc_out, 0);
      chk("small_restart_nf", small_if.nf_out, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
